hcsr04_medida_uc: RTL

- Control unit that sits directly upstream of the cm-counting datapath (tick generator plus 3-digit BCD counter) and drives it.
- On a start request it clears the datapath and fires the 10 us trigger pulse to the HC-SR04 sensor.
- It then synchronizes the sensor's echo, drives tick/BCD counting while echo is high, and reports pronto or timeout to the lift controller.

---
 rtl/hcsr04_medida_uc_pkg.sv | 29 ++
 rtl/hcsr04_medida_uc_edge_detector_sync.sv | 35 +++
 rtl/hcsr04_medida_uc.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hcsr04_medida_uc_pkg.sv
// rtl/hcsr04_medida_uc_pkg.sv - shared state encoding and timing defaults for the HC-SR04 measurement control unit
//
// Purpose: one place for the FSM state codes (also shown on the 7-seg debug
// display via db_estado) and the default trigger/timeout cycle counts.
// Ports: none (package).
// Optional feature macro used by the top level: HCSR04_AUTO_REPEAT_EN.

package hcsr04_medida_uc_pkg;

  // State codes double as the db_estado debug value.
  localparam logic [3:0] ST_INICIAL = 4'd0;
  localparam logic [3:0] ST_PREPARA = 4'd1;
  localparam logic [3:0] ST_TRIGGER = 4'd2;
  localparam logic [3:0] ST_ESPERA  = 4'd3;
  localparam logic [3:0] ST_MEDE    = 4'd4;
  localparam logic [3:0] ST_FINAL   = 4'd5;
  localparam logic [3:0] ST_ERRO    = 4'd6;

  // 10 us trigger and 60 ms echo budget at 50 MHz.
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_TIMEOUT_CYCLES = 3_000_000;
  localparam int DEF_W              = 23;

  // Both end states report completion to the lift controller.
  function automatic logic is_pronto(input logic [3:0] st);
    return (st == ST_FINAL) || (st == ST_ERRO);
  endfunction

endpackage

// File: rtl/hcsr04_medida_uc_edge_detector_sync.sv
// rtl/hcsr04_medida_uc_edge_detector_sync.sv - 2-flop synchronizer with rise/fall pulse outputs
//
// Purpose: bring an asynchronous level into the clock domain and flag its edges.
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous active-low reset
//   din    in   asynchronous input level
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
//   fall   out  one-cycle pulse on a synchronized 1->0 transition

module hcsr04_medida_uc_edge_detector_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;  // sync[1] is the synchronized level
  logic       level_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync    <= 2'b00;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], din};
      level_d <= sync[1];
    end
  end

  assign rise = sync[1] & ~level_d;
  assign fall = ~sync[1] & level_d;

endmodule

// File: rtl/hcsr04_medida_uc.sv
// rtl/hcsr04_medida_uc.sv - HC-SR04 measurement control unit driving the tick/BCD cm datapath
//
// Purpose: on a start request clear the datapath, fire the trigger pulse,
// count while echo is high and report pronto / timeout / saturado.
// Optional feature: HCSR04_AUTO_REPEAT_EN adds a free-running period counter
// that restarts a measurement every PERIOD_CYCLES (only while idle).
// Ports:
//   clock       in   system clock (50 MHz)
//   reset       in   asynchronous active-low reset
//   medir       in   start request, honoured only in INICIAL
//   echo        in   raw sensor echo (asynchronous)
//   tick        in   one-cycle cm tick from the datapath
//   fim         in   BCD counter saturated at 999
//   trigger     out  sensor trigger pulse
//   zera_tick   out  clear tick counter
//   conta_tick  out  tick counter enable
//   zera_bcd    out  clear BCD counter
//   conta_bcd   out  BCD increment enable (combinational on tick)
//   pronto      out  one-cycle end-of-measurement pulse
//   timeout     out  level, measurement ended on timeout
//   saturado    out  level, measurement ended on fim
//   db_estado   out  current state code

module hcsr04_medida_uc
  import hcsr04_medida_uc_pkg::*;
#(
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`ifdef HCSR04_AUTO_REPEAT_EN
  parameter int PERIOD_CYCLES  = 5_000_000,
`endif
  parameter int W              = DEF_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       echo,
  input  logic       tick,
  input  logic       fim,
  output logic       trigger,
  output logic       zera_tick,
  output logic       conta_tick,
  output logic       zera_bcd,
  output logic       conta_bcd,
  output logic       pronto,
  output logic       timeout,
  output logic       saturado,
  output logic [3:0] db_estado
);

  localparam logic [W-1:0] TRIG_LAST    = W'(TRIG_CYCLES - 1);
  localparam logic [W-1:0] TIMEOUT_LAST = W'(TIMEOUT_CYCLES - 1);

  logic [3:0]   state;
  logic [3:0]   next_state;
  logic [W-1:0] cnt;
  logic         timeout_q;
  logic         saturado_q;
  logic         rise;
  logic         fall;
  logic         start;
  logic         trig_done;
  logic         to_hit;

  hcsr04_medida_uc_edge_detector_sync u_echo_sync (
    .clock (clock),
    .reset (reset),
    .din   (echo),
    .rise  (rise),
    .fall  (fall)
  );

`ifdef HCSR04_AUTO_REPEAT_EN
  // Free-running from reset release; an expiry outside INICIAL is simply lost
  // because start is only looked at in INICIAL.
  logic [W-1:0] period_cnt;
  logic         period_hit;

  assign period_hit = (period_cnt == W'(PERIOD_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
    end else if (period_hit) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + W'(1);
    end
  end

  assign start = medir | period_hit;
`else
  assign start = medir;
`endif

  assign trig_done = (cnt == TRIG_LAST);
  assign to_hit    = (cnt == TIMEOUT_LAST);

  always_comb begin
    next_state = state;
    case (state)
      ST_INICIAL: if (start) next_state = ST_PREPARA;
      ST_PREPARA: next_state = ST_TRIGGER;
      ST_TRIGGER: if (trig_done) next_state = ST_ESPERA;
      // A rise in the same cycle as the timeout still starts the measurement.
      ST_ESPERA: begin
        if (rise)        next_state = ST_MEDE;
        else if (to_hit) next_state = ST_ERRO;
      end
      ST_MEDE: begin
        if (fall || fim) next_state = ST_FINAL;
        else if (to_hit) next_state = ST_ERRO;
      end
      ST_FINAL:   next_state = ST_INICIAL;
      ST_ERRO:    next_state = ST_INICIAL;
      default:    next_state = ST_INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_INICIAL;
      cnt        <= '0;
      timeout_q  <= 1'b0;
      saturado_q <= 1'b0;
    end else begin
      state <= next_state;

      // One counter serves both the trigger width and the echo budget;
      // it restarts at the TRIGGER->ESPERA boundary.
      case (state)
        ST_PREPARA: cnt <= '0;
        ST_TRIGGER: cnt <= trig_done ? '0 : cnt + W'(1);
        ST_ESPERA,
        ST_MEDE:    cnt <= cnt + W'(1);
        default:    cnt <= cnt;
      endcase

      // Status flags change on entry, so PREPARA already shows them clear
      // and FINAL/ERRO already show them set.
      if (state == ST_INICIAL && start) begin
        timeout_q  <= 1'b0;
        saturado_q <= 1'b0;
      end
      if (next_state == ST_ERRO) begin
        timeout_q <= 1'b1;
      end
      if (state == ST_MEDE && !fall && fim) begin
        saturado_q <= 1'b1;
      end
    end
  end

  assign trigger    = (state == ST_TRIGGER);
  assign zera_tick  = (state == ST_PREPARA);
  assign zera_bcd   = (state == ST_PREPARA);
  assign conta_tick = (state == ST_MEDE);
  // Combinational so a tick arriving in the fall cycle is not lost.
  assign conta_bcd  = (state == ST_MEDE) & tick;
  assign pronto     = is_pronto(state);
  assign timeout    = timeout_q;
  assign saturado   = saturado_q;
  assign db_estado  = state;

endmodule
